// File: rtl/stage_one_prefetch_if.sv
// Fetch front-end bus: program-memory port, decode stream,
// and redirect/halt control, grouped for the prefetch stage.
interface stage_one_prefetch_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt_sys;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;
    logic [CW-1:0]      q_count;
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc, halt_sys,
        output out_valid, out_instr, out_pc, out_pc_next,
        output q_count, halted,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc, halt_sys,
        input  out_valid, out_instr, out_pc, out_pc_next,
        input  q_count, halted,
        output out_ready
    );
endinterface

// File: rtl/stage_one_prefetch.sv
// Instruction-fetch front end: PC, 1-cycle program memory port,
// prefetch queue to decode, redirect flush and system halt.
module stage_one_prefetch #(
    parameter int                INSTR_W  = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    stage_one_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [CW-1:0]     CAP  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  infl_pc;
    logic               inflight;

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic has_room;
    logic flush;
    logic req;
    logic accept;
    logic push;
    logic pop;
    logic out_valid;

    // The outstanding request reserves a slot so the queue cannot overflow.
    assign has_room  = (count + CW'(inflight)) < CAP;
    assign flush     = bus.redirect && (state != IDLE);
    assign req       = (state == RUN) && !bus.halt_sys
                       && !bus.redirect && has_room;
    assign accept    = req && bus.imem_gnt;
    // Only a response owed to us is kept; after a flush inflight is 0.
    assign push      = inflight && bus.imem_rvalid && !flush;
    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? q_instr[head] : '0;
    assign bus.out_pc      = out_valid ? q_pc[head] : '0;
    assign bus.out_pc_next = bus.out_pc + STEP;
    assign bus.q_count     = count;
    assign bus.halted      = (state == HALTED);

    // Fetch control: start-up, running, drain of last response, halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= RUN;
                RUN: begin
                    if (bus.halt_sys)
                        state <= inflight ? DRAIN : HALTED;
                end
                DRAIN:   state <= HALTED;
                HALTED: begin
                    if (!bus.halt_sys)
                        state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PC advance on accepted requests, reload on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            infl_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept)
                infl_pc <= pc;
            if (flush)
                pc <= bus.redirect_pc;
            else if (accept)
                pc <= pc + STEP;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents are only visible while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= bus.imem_rdata;
            q_pc[tail]    <= infl_pc;
        end
    end

endmodule

// File: tb/tb_stage_one_prefetch.sv
// Randomised and directed bench for stage_one_prefetch against
// a queue-based reference model of the fetch front end.
module tb_stage_one_prefetch;
    localparam int IW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stage_one_prefetch_if #(
        .INSTR_W(IW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) bus ();

    stage_one_prefetch #(
        .INSTR_W (IW),
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .PC_STEP (2),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ent_t        mq[$];
    int          mode;
    logic [15:0] m_pc;
    logic [15:0] m_ipc;
    bit          m_infl;
    bit          seen_valid;
    logic [15:0] dlv_pc[$];
    logic [15:0] dlv_nx[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mode   = M_IDLE;
        m_pc   = 16'h0000;
        m_ipc  = 16'h0000;
        m_infl = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        bit          ereq;
        bit          evalid;
        bit          acc;
        bit          pop;
        bit          push;
        bit          flush;
        ent_t        e;
        logic [15:0] rd;
        logic [15:0] pc0;
        #1;
        evalid = mq.size() != 0;
        e = evalid ? mq[0] : '0;
        ereq = (mode == M_RUN) && !bus.halt_sys && !bus.redirect
               && ((mq.size() + int'(m_infl)) < DEPTH);
        check("req", bus.imem_req, ereq);
        check("addr", bus.imem_addr, m_pc);
        check("valid", bus.out_valid, evalid);
        check("instr", bus.out_instr, e.instr);
        check("pc", bus.out_pc, e.pc);
        check("pc_next", bus.out_pc_next, 16'(e.pc + 16'd2));
        check("count", bus.q_count, mq.size());
        check("halted", bus.halted, mode == M_HALT);
        seen_valid = bus.out_valid;
        acc   = ereq && bus.imem_gnt;
        pop   = evalid && bus.out_ready;
        flush = bus.redirect && (mode != M_IDLE);
        push  = m_infl && bus.imem_rvalid && !flush;
        rd    = bus.imem_rdata;
        pc0   = m_pc;
        if (pop) begin
            dlv_pc.push_back(bus.out_pc);
            dlv_nx.push_back(bus.out_pc_next);
        end
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_pc = bus.redirect_pc;
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (push)
                mq.push_back('{instr: rd, pc: m_ipc});
            if (acc)
                m_pc = pc0 + 16'd2;
        end
        if (acc)
            m_ipc = pc0;
        case (mode)
            M_IDLE:  mode = M_RUN;
            M_RUN:   if (bus.halt_sys) mode = m_infl ? M_DRAIN : M_HALT;
            M_DRAIN: mode = M_HALT;
            default: if (!bus.halt_sys) mode = M_RUN;
        endcase
        m_infl = acc;
        @(negedge clk);
        bus.imem_rvalid = acc;
        bus.imem_rdata  = acc ? 16'hA000 + pc0 : 16'($urandom);
    endtask

    // Asserts reset a little after a falling edge, releases on a later one.
    task automatic do_reset(int hold);
        #2 rst = 1'b0;
        #1;
        check("rst_req", bus.imem_req, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_instr", bus.out_instr, 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_count", bus.q_count, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_addr", bus.imem_addr, 0);
        model_reset();
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int          first;
        int          c0;
        logic [15:0] hp;

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.halt_sys    = 1'b0;
        bus.out_ready   = 1'b0;
        do_reset(2);

        // Fetch: first valid after the third edge following release.
        bus.imem_gnt  = 1'b1;
        bus.out_ready = 1'b1;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (first < 0 && seen_valid)
                first = i;
        end
        check("latency", first, 4);

        // Stall: queue fills to DEPTH and issue stops.
        bus.out_ready = 1'b0;
        repeat (10) cycle();
        #1;
        check("stall_cnt", bus.q_count, 4);
        check("stall_req", bus.imem_req, 0);

        // Redirect with three queued and one in flight.
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        cycle();
        check("rd_cnt", bus.q_count, 3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        cycle();
        bus.redirect = 1'b0;
        check("rd_flush", bus.q_count, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid)
                break;
            cycle();
        end
        check("rd_pc", bus.out_pc, 16'h0100);
        repeat (4) cycle();

        // Halt with a response pending.
        bus.out_ready = 1'b0;
        bus.halt_sys  = 1'b1;
        c0 = mq.size();
        cycle();
        check("halt_q", bus.q_count, c0 + 1);
        cycle();
        check("halted_on", bus.halted, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_req", bus.imem_req, 0);
            cycle();
        end
        hp = m_pc;
        bus.halt_sys  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        #1;
        check("resume_req", bus.imem_req, 1);
        check("resume_addr", bus.imem_addr, hp);
        cycle();

        // Wrap through the top of the address space.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFC;
        cycle();
        bus.redirect = 1'b0;
        dlv_pc.delete();
        dlv_nx.delete();
        repeat (8) cycle();
        check("wrap_n", dlv_pc.size() >= 3, 1);
        if (dlv_pc.size() >= 3) begin
            check("wrap_pc0", dlv_pc[0], 16'hFFFC);
            check("wrap_pc1", dlv_pc[1], 16'hFFFE);
            check("wrap_pc2", dlv_pc[2], 16'h0000);
            check("wrap_nx1", dlv_nx[1], 16'h0000);
        end

        // Grant backpressure, then reset with a request outstanding.
        for (int i = 0; i < 9; i++) begin
            bus.imem_gnt = (i % 3) != 1;
            cycle();
        end
        bus.imem_gnt = 1'b1;
        do_reset(2);
        dlv_pc.delete();
        repeat (6) cycle();
        check("rst_fetch_n", dlv_pc.size() >= 1, 1);
        if (dlv_pc.size() >= 1)
            check("rst_fetch_pc", dlv_pc[0], 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.imem_gnt    = $urandom_range(0, 9) < 7;
            bus.out_ready   = $urandom_range(0, 9) < 6;
            bus.redirect    = $urandom_range(0, 19) == 0;
            bus.redirect_pc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 19) == 0)
                bus.halt_sys = !bus.halt_sys;
            if ($urandom_range(0, 199) == 0)
                do_reset(1);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
